// File: rtl/bsg_dramsim3_pkg.sv
// Shared DRAMSim3 definitions: the address-mapping selector used by the mapper and the unmapper.
package bsg_dramsim3_pkg;

  typedef enum logic [1:0] {
    e_ro_ra_bg_ba_co_ch = 2'd0,
    e_ro_ra_bg_ba_ch_co = 2'd1,
    e_ro_ch_ra_ba_bg_co = 2'd2
  } bsg_dramsim3_address_mapping_e;

endpackage

// File: rtl/bsg_nonsynth_dramsim3_unmap_pkg.sv
// Width helpers shared by the unmapper, its decoder and its interface users.
package bsg_nonsynth_dramsim3_unmap_pkg;

  // Like $clog2, but never returns 0 so a one-entry field still gets one bit.
  function automatic int unsigned safe_clog2(input int unsigned x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

  function automatic int unsigned count_width(input int unsigned els);
    return $clog2(els + 1);
  endfunction

  function automatic bit is_pow2(input int unsigned x);
    return (x != 0) && ((x & (x - 1)) == 0);
  endfunction

endpackage

// File: rtl/bsg_nonsynth_dramsim3_unmap_if.sv
// Completion-address in / decoded-entry out handshake bundle of the DRAMSim3 unmapper.
interface bsg_nonsynth_dramsim3_unmap_if #(
  parameter int unsigned addr_width_p         = 33,
  parameter int unsigned ch_width_p           = 1,
  parameter int unsigned channel_addr_width_p = 32,
  parameter int unsigned count_width_p        = 3
);

  logic                            v_i;
  logic [addr_width_p-1:0]         mem_addr_i;
  logic                            ready_o;
  logic                            v_o;
  logic [ch_width_p-1:0]           ch_o;
  logic [channel_addr_width_p-1:0] ch_addr_o;
  logic                            yumi_i;
  logic                            misaligned_o;
  logic [count_width_p-1:0]        count_o;

  // Poller and response demux side.
  modport master (
    output v_i, mem_addr_i, yumi_i,
    input  ready_o, v_o, ch_o, ch_addr_o, misaligned_o, count_o
  );

  // Unmapper side.
  modport slave (
    input  v_i, mem_addr_i, yumi_i,
    output ready_o, v_o, ch_o, ch_addr_o, misaligned_o, count_o
  );

endinterface

// File: rtl/bsg_nonsynth_dramsim3_unmap_decode.sv
// Combinational inverse of the DRAMSim3 channel address mapper: global address -> {ch, ch_addr}.
module bsg_nonsynth_dramsim3_unmap_decode
  import bsg_dramsim3_pkg::*;
  import bsg_nonsynth_dramsim3_unmap_pkg::*;
#(
  parameter int unsigned channel_addr_width_p = 32,
  parameter int unsigned data_width_p         = 64,
  parameter int unsigned num_channels_p       = 2,
  parameter int unsigned num_columns_p        = 1024,
  parameter int unsigned num_rows_p           = 32768,
  parameter int unsigned num_ba_p             = 4,
  parameter int unsigned num_bg_p             = 4,
  parameter int unsigned num_ranks_p          = 1,
  parameter bsg_dramsim3_address_mapping_e address_mapping_p = e_ro_ra_bg_ba_co_ch,
  localparam int unsigned lg_num_channels_lp = $clog2(num_channels_p),
  localparam int unsigned addr_width_lp      = lg_num_channels_lp + channel_addr_width_p,
  localparam int unsigned ch_width_lp        = safe_clog2(num_channels_p)
) (
  input  logic [addr_width_lp-1:0]        mem_addr_i,
  output logic [ch_width_lp-1:0]          ch_o,
  output logic [channel_addr_width_p-1:0] ch_addr_o
);

  localparam int unsigned bo_lp     = safe_clog2(data_width_p / 8);
  localparam int unsigned lg_col_lp = $clog2(num_columns_p);
  localparam int unsigned lg_ba_lp  = $clog2(num_ba_p);
  localparam int unsigned lg_bg_lp  = $clog2(num_bg_p);
  localparam int unsigned lg_ra_lp  = $clog2(num_ranks_p);
  localparam int unsigned lg_ro_lp  = $clog2(num_rows_p);
  localparam int unsigned lg_ch_lp  = lg_num_channels_lp;

  // Rows take whatever is left above the fixed fields, so the channel address must cover them.
  if (channel_addr_width_p < bo_lp + lg_col_lp + lg_ba_lp + lg_bg_lp + lg_ra_lp + lg_ro_lp) begin : g_narrow
    $fatal(1, "channel_addr_width_p too narrow for the configured DRAM geometry");
  end

  // Extracts a field of 'width' bits at 'pos'; zero-width fields yield 0.
  function automatic logic [addr_width_lp-1:0] get_field(input logic [addr_width_lp-1:0] a,
                                                         input int unsigned pos,
                                                         input int unsigned width);
    logic [addr_width_lp-1:0] mask;
    mask = (addr_width_lp'(1) << width) - addr_width_lp'(1);
    return (a >> pos) & mask;
  endfunction

  if (address_mapping_p == e_ro_ra_bg_ba_co_ch) begin : g_co_ch
    localparam int unsigned ch_pos_lp = bo_lp;
    localparam int unsigned hi_pos_lp = bo_lp + lg_ch_lp;

    assign ch_o      = ch_width_lp'(get_field(mem_addr_i, ch_pos_lp, lg_ch_lp));
    assign ch_addr_o = channel_addr_width_p'((mem_addr_i >> hi_pos_lp) << bo_lp);

  end else if (address_mapping_p == e_ro_ra_bg_ba_ch_co) begin : g_ch_co
    localparam int unsigned ch_pos_lp = bo_lp + lg_col_lp;
    localparam int unsigned hi_pos_lp = bo_lp + lg_col_lp + lg_ch_lp;

    assign ch_o      = ch_width_lp'(get_field(mem_addr_i, ch_pos_lp, lg_ch_lp));
    assign ch_addr_o = channel_addr_width_p'(((mem_addr_i >> hi_pos_lp) << ch_pos_lp)
                     | (get_field(mem_addr_i, bo_lp, lg_col_lp) << bo_lp));

  end else if (address_mapping_p == e_ro_ch_ra_ba_bg_co) begin : g_ro_ch
    // Memory side from the LSB: offset, co, bg, ba, ra, ch, ro.
    localparam int unsigned m_bg_pos_lp = bo_lp + lg_col_lp;
    localparam int unsigned m_ba_pos_lp = m_bg_pos_lp + lg_bg_lp;
    localparam int unsigned m_ra_pos_lp = m_ba_pos_lp + lg_ba_lp;
    localparam int unsigned m_ch_pos_lp = m_ra_pos_lp + lg_ra_lp;
    localparam int unsigned m_ro_pos_lp = m_ch_pos_lp + lg_ch_lp;
    // Channel side from the LSB: offset, co, ba, bg, ra, ro.
    localparam int unsigned c_ba_pos_lp = bo_lp + lg_col_lp;
    localparam int unsigned c_bg_pos_lp = c_ba_pos_lp + lg_ba_lp;
    localparam int unsigned c_ra_pos_lp = c_bg_pos_lp + lg_bg_lp;
    localparam int unsigned c_ro_pos_lp = c_ra_pos_lp + lg_ra_lp;

    logic [addr_width_lp-1:0] co, bg, ba, ra, ro;

    assign co = get_field(mem_addr_i, bo_lp, lg_col_lp);
    assign bg = get_field(mem_addr_i, m_bg_pos_lp, lg_bg_lp);
    assign ba = get_field(mem_addr_i, m_ba_pos_lp, lg_ba_lp);
    assign ra = get_field(mem_addr_i, m_ra_pos_lp, lg_ra_lp);
    assign ro = mem_addr_i >> m_ro_pos_lp;

    assign ch_o      = ch_width_lp'(get_field(mem_addr_i, m_ch_pos_lp, lg_ch_lp));
    assign ch_addr_o = channel_addr_width_p'((co << bo_lp)
                     | (ba << c_ba_pos_lp)
                     | (bg << c_bg_pos_lp)
                     | (ra << c_ra_pos_lp)
                     | (ro << c_ro_pos_lp));

  end else begin : g_bad_map
    $fatal(1, "bsg_nonsynth_dramsim3_unmap: unknown address_mapping_p");
    assign ch_o      = '0;
    assign ch_addr_o = '0;
  end

endmodule

// File: rtl/bsg_nonsynth_dramsim3_unmap.sv
// DRAMSim3 completion unmapper: decodes global addresses and queues {ch, ch_addr} in order.
module bsg_nonsynth_dramsim3_unmap
  import bsg_dramsim3_pkg::*;
  import bsg_nonsynth_dramsim3_unmap_pkg::*;
#(
  parameter int unsigned channel_addr_width_p = 32,
  parameter int unsigned data_width_p         = 64,
  parameter int unsigned num_channels_p       = 2,
  parameter int unsigned num_columns_p        = 1024,
  parameter int unsigned num_rows_p           = 32768,
  parameter int unsigned num_ba_p             = 4,
  parameter int unsigned num_bg_p             = 4,
  parameter int unsigned num_ranks_p          = 1,
  parameter bsg_dramsim3_address_mapping_e address_mapping_p = e_ro_ra_bg_ba_co_ch,
  parameter int unsigned els_p                = 4,
  localparam int unsigned lg_num_channels_lp = $clog2(num_channels_p),
  localparam int unsigned addr_width_lp      = lg_num_channels_lp + channel_addr_width_p,
  localparam int unsigned ch_width_lp        = safe_clog2(num_channels_p),
  localparam int unsigned count_width_lp     = count_width(els_p)
) (
  input logic                          clk_i,
  input logic                          reset_i,
  bsg_nonsynth_dramsim3_unmap_if.slave io
);

  localparam int unsigned bo_lp     = safe_clog2(data_width_p / 8);
  localparam int unsigned lg_els_lp = $clog2(els_p);

  if (!is_pow2(els_p) || els_p < 2) begin : g_bad_els
    $fatal(1, "bsg_nonsynth_dramsim3_unmap: els_p must be a power of two >= 2");
  end

  logic [ch_width_lp-1:0]          dec_ch;
  logic [channel_addr_width_p-1:0] dec_ch_addr;

  bsg_nonsynth_dramsim3_unmap_decode #(
    .channel_addr_width_p(channel_addr_width_p),
    .data_width_p        (data_width_p),
    .num_channels_p      (num_channels_p),
    .num_columns_p       (num_columns_p),
    .num_rows_p          (num_rows_p),
    .num_ba_p            (num_ba_p),
    .num_bg_p            (num_bg_p),
    .num_ranks_p         (num_ranks_p),
    .address_mapping_p   (address_mapping_p)
  ) decode (
    .mem_addr_i(io.mem_addr_i),
    .ch_o      (dec_ch),
    .ch_addr_o (dec_ch_addr)
  );

  logic [lg_els_lp-1:0]      rd_ptr_q, rd_ptr_d;
  logic [lg_els_lp-1:0]      wr_ptr_q, wr_ptr_d;
  logic [count_width_lp-1:0] count_q, count_d;
  logic                      misaligned_q, misaligned_d;

  logic [ch_width_lp-1:0]          ch_mem_q   [els_p];
  logic [channel_addr_width_p-1:0] addr_mem_q [els_p];

  logic push, pop, offset_nz;

  assign io.ready_o = (count_q != count_width_lp'(els_p));
  assign io.v_o     = (count_q != '0);

  assign push      = io.v_i & io.ready_o;
  assign pop       = io.yumi_i & io.v_o;
  assign offset_nz = |io.mem_addr_i[bo_lp-1:0];

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    misaligned_d = misaligned_q | (push & offset_nz);
    if (push) wr_ptr_d = wr_ptr_q + lg_els_lp'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + lg_els_lp'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + count_width_lp'(1);
      2'b01:   count_d = count_q - count_width_lp'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Storage needs no reset: slots are only read once count marks them valid.
  always_ff @(posedge clk_i) begin
    if (!reset_i && push) begin
      ch_mem_q[wr_ptr_q]   <= dec_ch;
      addr_mem_q[wr_ptr_q] <= dec_ch_addr;
    end
  end

  assign io.ch_o         = ch_mem_q[rd_ptr_q];
  assign io.ch_addr_o    = addr_mem_q[rd_ptr_q];
  assign io.misaligned_o = misaligned_q;
  assign io.count_o      = count_q;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(io.yumi_i && !io.v_o))
        else $error("bsg_nonsynth_dramsim3_unmap: yumi_i asserted while v_o=0");
    end
  end

endmodule

// File: tb/tb_bsg_nonsynth_dramsim3_unmap.sv
// Directed bench: three unmappers (one per mapping) driven in lockstep and checked against a
// field-permutation model with an in-order expected queue.
module tb_bsg_nonsynth_dramsim3_unmap;
  import bsg_dramsim3_pkg::*;

  localparam int AW = 33;
  localparam int CAW = 32;

  // Field ids and per-mapping memory field order from the LSB (above the 3-bit byte offset).
  localparam int FCO = 0, FBG = 1, FBA = 2, FRA = 3, FCH = 4, FRO = 5;
  localparam int MORD [3][6] = '{'{4, 0, 2, 1, 3, 5}, '{0, 4, 2, 1, 3, 5}, '{0, 1, 2, 3, 4, 5}};
  localparam int CORD [5] = '{0, 2, 1, 3, 5};

  logic clk = 1'b0;
  logic reset;
  logic v, yumi;
  logic [AW-1:0] a [3];
  bit run = 1'b0;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  bsg_nonsynth_dramsim3_unmap_if #(.addr_width_p(AW), .ch_width_p(1), .channel_addr_width_p(CAW),
    .count_width_p(3)) if0 ();
  bsg_nonsynth_dramsim3_unmap_if #(.addr_width_p(AW), .ch_width_p(1), .channel_addr_width_p(CAW),
    .count_width_p(3)) if1 ();
  bsg_nonsynth_dramsim3_unmap_if #(.addr_width_p(AW), .ch_width_p(1), .channel_addr_width_p(CAW),
    .count_width_p(3)) if2 ();

  bsg_nonsynth_dramsim3_unmap #(.address_mapping_p(e_ro_ra_bg_ba_co_ch), .els_p(4))
    dut0 (.clk_i(clk), .reset_i(reset), .io(if0));
  bsg_nonsynth_dramsim3_unmap #(.address_mapping_p(e_ro_ra_bg_ba_ch_co), .els_p(4))
    dut1 (.clk_i(clk), .reset_i(reset), .io(if1));
  bsg_nonsynth_dramsim3_unmap #(.address_mapping_p(e_ro_ch_ra_ba_bg_co), .els_p(4))
    dut2 (.clk_i(clk), .reset_i(reset), .io(if2));

  assign if0.v_i = v;  assign if0.mem_addr_i = a[0];  assign if0.yumi_i = yumi;
  assign if1.v_i = v;  assign if1.mem_addr_i = a[1];  assign if1.yumi_i = yumi;
  assign if2.v_i = v;  assign if2.mem_addr_i = a[2];  assign if2.yumi_i = yumi;

  logic dv [3], drdy [3], dmis [3], dch [3];
  logic [CAW-1:0] daddr [3];
  logic [2:0] dcnt [3];

  assign dv[0] = if0.v_o;  assign drdy[0] = if0.ready_o;  assign dmis[0] = if0.misaligned_o;
  assign dch[0] = if0.ch_o;  assign daddr[0] = if0.ch_addr_o;  assign dcnt[0] = if0.count_o;
  assign dv[1] = if1.v_o;  assign drdy[1] = if1.ready_o;  assign dmis[1] = if1.misaligned_o;
  assign dch[1] = if1.ch_o;  assign daddr[1] = if1.ch_addr_o;  assign dcnt[1] = if1.count_o;
  assign dv[2] = if2.v_o;  assign drdy[2] = if2.ready_o;  assign dmis[2] = if2.misaligned_o;
  assign dch[2] = if2.ch_o;  assign daddr[2] = if2.ch_addr_o;  assign dcnt[2] = if2.count_o;

  function automatic int fw(input int id);
    case (id)
      FCO:     return 10;
      FBG:     return 2;
      FBA:     return 2;
      FRA:     return 0;
      FCH:     return 1;
      default: return 15;
    endcase
  endfunction

  // Model decode: pull named fields out of the memory layout, lay them down in channel order.
  function automatic logic [32:0] model_unmap(input int m, input logic [AW-1:0] mem);
    longint unsigned vals [6];
    longint unsigned addr;
    int pos;
    addr = 0;
    pos = 3;
    for (int i = 0; i < 6; i++) begin
      vals[MORD[m][i]] = (longint'(mem) >> pos) & ((64'd1 << fw(MORD[m][i])) - 1);
      pos += fw(MORD[m][i]);
    end
    pos = 3;
    for (int i = 0; i < 5; i++) begin
      addr |= vals[CORD[i]] << pos;
      pos += fw(CORD[i]);
    end
    return {vals[FCH][0], addr[31:0]};
  endfunction

  // Forward mapper: the same permutation in the opposite direction.
  function automatic logic [AW-1:0] forward(input int m, input logic ch, input logic [CAW-1:0] ca);
    longint unsigned vals [6];
    longint unsigned mem;
    int pos;
    mem = 0;
    pos = 3;
    for (int i = 0; i < 5; i++) begin
      vals[CORD[i]] = (longint'(ca) >> pos) & ((64'd1 << fw(CORD[i])) - 1);
      pos += fw(CORD[i]);
    end
    vals[FCH] = longint'(ch);
    pos = 3;
    for (int i = 0; i < 6; i++) begin
      mem |= vals[MORD[m][i]] << pos;
      pos += fw(MORD[m][i]);
    end
    return mem[AW-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: one expected queue and one sticky flag per instance.
  logic [32:0] mq [3][$];
  bit mmis [3];

  always @(posedge clk) begin
    for (int m = 0; m < 3; m++) begin
      if (reset) begin
        mq[m].delete();
        mmis[m] = 1'b0;
      end else begin
        bit acc;
        acc = v && (mq[m].size() != 4);
        if (yumi && mq[m].size() != 0) void'(mq[m].pop_front());
        if (acc) begin
          mq[m].push_back(model_unmap(m, a[m]));
          if (a[m][2:0] != 3'b0) mmis[m] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      for (int m = 0; m < 3; m++) begin
        chk($sformatf("count[%0d]", m), 64'(dcnt[m]), 64'(mq[m].size()));
        chk($sformatf("v[%0d]", m), 64'(dv[m]), 64'(mq[m].size() != 0));
        chk($sformatf("ready[%0d]", m), 64'(drdy[m]), 64'(mq[m].size() != 4));
        chk($sformatf("misaligned[%0d]", m), 64'(dmis[m]), 64'(mmis[m]));
        if (mq[m].size() != 0) begin
          chk($sformatf("head[%0d]", m), 64'({dch[m], daddr[m]}), 64'(mq[m][0]));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [AW-1:0] val);
    for (int m = 0; m < 3; m++) a[m] = val;
  endtask

  task automatic push1(input logic [AW-1:0] val);
    set_all(val);
    v = 1'b1;
    step();
    v = 1'b0;
  endtask

  task automatic pop1();
    yumi = 1'b1;
    step();
    yumi = 1'b0;
  endtask

  logic rch [3];
  logic [CAW-1:0] raddr [3];

  initial begin
    reset = 1'b1;
    v = 1'b0;
    yumi = 1'b0;
    set_all('0);
    step();
    run = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("reset count", 64'(dcnt[0]), 64'd0);
    chk("reset v", 64'(dv[0]), 64'd0);
    chk("reset ready", 64'(drdy[0]), 64'd1);
    chk("reset misaligned", 64'(dmis[0]), 64'd0);

    // One known address per mapping.
    push1(33'h0_0000_0048);
    chk("co_ch v", 64'(dv[0]), 64'd1);
    chk("co_ch ch", 64'(dch[0]), 64'd1);
    chk("co_ch addr", 64'(daddr[0]), 64'h20);
    pop1();
    push1(33'h0_0000_2010);
    chk("ch_co ch", 64'(dch[1]), 64'd1);
    chk("ch_co addr", 64'(daddr[1]), 64'h10);
    pop1();
    push1(33'h0_0007_2000);
    chk("ro_ch ch", 64'(dch[2]), 64'd1);
    chk("ro_ch addr", 64'(daddr[2]), 64'h2C000);
    pop1();

    // Fill past capacity: the fifth push is refused.
    for (int i = 0; i < 5; i++) begin
      set_all(33'((i + 1) * 64 + 8 * (i & 1)));
      v = 1'b1;
      step();
      if (i == 3) begin
        chk("full count", 64'(dcnt[0]), 64'd4);
        chk("full ready", 64'(drdy[0]), 64'd0);
      end
    end
    v = 1'b0;
    chk("fifth refused", 64'(dcnt[0]), 64'd4);
    repeat (4) pop1();
    chk("drained v", 64'(dv[0]), 64'd0);

    // Streaming push+pop across pointer wrap.
    for (int i = 0; i < 3; i++) push1(33'h1_0000_0000 | 33'(i * 8 + 'h4000));
    v = 1'b1;
    yumi = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_all(33'h0_1234_0000 + 33'(i * 'h2008));
      step();
    end
    v = 1'b0;
    yumi = 1'b0;
    chk("stream count", 64'(dcnt[0]), 64'd3);
    push1(33'h0_0000_6018);
    chk("refill count", 64'(dcnt[0]), 64'd4);

    // Pop with a push offered while full: only the pop takes effect.
    set_all(33'h0_0000_0808);
    v = 1'b1;
    yumi = 1'b1;
    step();
    yumi = 1'b0;
    chk("full pop+push", 64'(dcnt[0]), 64'd3);

    // Reset with a push pending flushes everything.
    reset = 1'b1;
    step();
    reset = 1'b0;
    v = 1'b0;
    chk("flush count", 64'(dcnt[0]), 64'd0);
    chk("flush v", 64'(dv[0]), 64'd0);

    // Sticky misalignment.
    push1(33'h0_0000_0049);
    chk("misaligned set", 64'(dmis[0]), 64'd1);
    pop1();
    repeat (3) step();
    chk("misaligned held", 64'(dmis[0]), 64'd1);

    // Round trip through the forward mapper.
    for (int k = 0; k < 8; k++) begin
      for (int m = 0; m < 3; m++) begin
        rch[m] = 1'($urandom_range(0, 1));
        raddr[m] = $urandom & 32'hFFFF_FFF8;
        a[m] = forward(m, rch[m], raddr[m]);
      end
      v = 1'b1;
      step();
      v = 1'b0;
      for (int m = 0; m < 3; m++) begin
        chk($sformatf("rt ch[%0d]", m), 64'(dch[m]), 64'(rch[m]));
        chk($sformatf("rt addr[%0d]", m), 64'(daddr[m]), 64'(raddr[m]));
      end
      pop1();
    end

    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("misaligned cleared", 64'(dmis[0]), 64'd0);
    chk("final count", 64'(dcnt[0]), 64'd0);

    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
